// File: rtl/pipeline_mdu_pkg.sv
// Shared types and constants for the pipeline multiply/divide unit.
package MduCtrl;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

  // Wide enough for any XLEN in use; users slice the low XLEN bits.
  localparam logic [127:0] MDU_DIV0_LO = '1;

endpackage

// File: rtl/pipeline_mdu_if.sv
// EXE-stage <-> MDU signal bundle; the pipeline is master, the MDU is slave.
interface pipeline_mdu_if
  import MduCtrl::*;
#(
  parameter int XLEN = 32
);
  logic            start;
  mdu_op_t         op;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            clear_exe;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, op, srca, srcb, clear_exe, input busy, hi, lo);
  modport slave  (input start, op, srca, srcb, clear_exe, output busy, hi, lo);
endinterface

// File: rtl/pipeline_mdu_divider.sv
// Restoring unsigned divider: load latches operands, each step produces one quotient bit.
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dsr;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;

  // The quotient register doubles as the dividend shifter.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_dsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dsr <= '0;
    end else if (load) begin
      r_rem <= '0;
      r_quo <= dividend;
      r_dsr <= divisor;
    end else if (step) begin
      if (w_trial[XLEN]) begin
        r_rem <= w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end else begin
        r_rem <= w_trial[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
endmodule

// File: rtl/pipeline_mdu.sv
// Iterative multiply/divide unit with HI/LO registers for the EXE stage.
// Optional MDU_FAST_MUL_EN: single-cycle combinational MULT/MULTU.
module pipeline_mdu
  import MduCtrl::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  pipeline_mdu_if.slave  mdu
);
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  mdu_state_t        r_state;
  mdu_state_t        w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_raw_a;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_is_div;
  logic              r_div0;

  logic              w_accept;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_signed;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [2*XLEN-1:0] w_fast_mag;
  logic [2*XLEN-1:0] w_fast_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  assign w_accept = mdu.start && !mdu.clear_exe && (r_state == IDLE) && (mdu.op != MDU_NONE);
  assign w_is_mul = (mdu.op == MDU_MULT) || (mdu.op == MDU_MULTU);
  assign w_is_div = (mdu.op == MDU_DIV)  || (mdu.op == MDU_DIVU);
  assign w_signed = (mdu.op == MDU_MULT) || (mdu.op == MDU_DIV);
  assign w_sa     = w_signed && mdu.srca[XLEN-1];
  assign w_sb     = w_signed && mdu.srcb[XLEN-1];
  // Negating the most negative value wraps to itself, read as magnitude 2^(XLEN-1).
  assign w_mag_a  = w_sa ? (~mdu.srca + XLEN'(1)) : mdu.srca;
  assign w_mag_b  = w_sb ? (~mdu.srcb + XLEN'(1)) : mdu.srcb;

  // Right-shifting shift-add: multiplier starts in the low half of the accumulator.
  assign w_sum       = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_fix  = r_neg_q ? (~r_acc + (2*XLEN)'(1)) : r_acc;
  assign w_fast_mag  = {XLEN'(0), w_mag_a} * {XLEN'(0), w_mag_b};
  assign w_fast_prod = (w_sa ^ w_sb) ? (~w_fast_mag + (2*XLEN)'(1)) : w_fast_mag;

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_accept && w_is_div),
    .step      (r_state == DIV),
    .dividend  (w_mag_a),
    .divisor   (w_mag_b),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_div)                 w_state_next = DIV;
        else if (w_accept && w_is_mul && !FAST_MUL) w_state_next = MUL;
      end
      MUL, DIV: if (r_cnt == CNT_W'(1)) w_state_next = FIX;
      FIX:      w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_raw_a  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= CNT_W'(XLEN);
        r_neg_q  <= w_sa ^ w_sb;
        r_neg_r  <= w_sa;
        r_is_div <= w_is_div;
        r_div0   <= (mdu.srcb == '0);
        r_raw_a  <= mdu.srca;
        r_acc    <= {XLEN'(0), w_mag_b};
        r_mcand  <= w_mag_a;
        if (mdu.op == MDU_MTHI) r_hi <= mdu.srca;
        if (mdu.op == MDU_MTLO) r_lo <= mdu.srca;
        if (w_is_mul && FAST_MUL) begin
          r_hi <= w_fast_prod[2*XLEN-1:XLEN];
          r_lo <= w_fast_prod[XLEN-1:0];
        end
      end
      case (r_state)
        MUL: begin
          r_acc <= {w_sum, r_acc[XLEN-1:1]};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        DIV: r_cnt <= r_cnt - CNT_W'(1);
        FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod_fix[2*XLEN-1:XLEN];
            r_lo <= w_prod_fix[XLEN-1:0];
          end else if (r_div0) begin
            r_hi <= r_raw_a;
            r_lo <= MDU_DIV0_LO[XLEN-1:0];
          end else begin
            r_hi <= r_neg_r ? (~w_rem + XLEN'(1)) : w_rem;
            r_lo <= r_neg_q ? (~w_quo + XLEN'(1)) : w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign mdu.busy = (r_state != IDLE);
  assign mdu.hi   = r_hi;
  assign mdu.lo   = r_lo;
endmodule

// File: tb/tb_pipeline_mdu.sv
// Scoreboard bench for pipeline_mdu: driver pushes model results, monitor checks at completion.
module tb_pipeline_mdu;
  import MduCtrl::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          lat;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   issued = 0;
  int   mon_done = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  exp_t sb_q[$];

  pipeline_mdu_if #(.XLEN(32)) mif ();

  pipeline_mdu #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions.
  task automatic model(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input bit clr, output exp_t e);
    logic [63:0] p;
    longint      q;
    longint      r;
    e.old_hi = m_hi;
    e.old_lo = m_lo;
    e.lat    = 0;
    e.name   = clr ? "clr" : op.name();
    if (!clr) begin
      case (op)
        MDU_MTHI: m_hi = a;
        MDU_MTLO: m_lo = a;
        MDU_MULT: begin
          p = longint'($signed(a)) * longint'($signed(b));
          m_hi = p[63:32]; m_lo = p[31:0]; e.lat = MUL_LAT;
        end
        MDU_MULTU: begin
          p = {32'd0, a} * {32'd0, b};
          m_hi = p[63:32]; m_lo = p[31:0]; e.lat = MUL_LAT;
        end
        MDU_DIV, MDU_DIVU: begin
          e.lat = DIV_LAT;
          if (b == 0) begin
            m_lo = 32'hFFFF_FFFF; m_hi = a;
          end else if (op == MDU_DIV) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            m_lo = q[31:0]; m_hi = r[31:0];
          end else begin
            m_lo = a / b; m_hi = a % b;
          end
        end
        default: ;
      endcase
    end
    e.hi = m_hi;
    e.lo = m_lo;
  endtask

  task automatic wait_mon();
    for (int i = 0; i < 200 && mon_done != issued; i++) @(negedge clk);
    if (mon_done != issued) begin
      errors++;
      $display("FAIL monitor_timeout: got %0d done expected %0d", mon_done, issued);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "monitor stalled");
    end
  endtask

  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input bit clr, input bit intrude);
    exp_t e;
    @(negedge clk);
    model(op, a, b, clr, e);
    sb_q.push_back(e);
    issued++;
    mif.start = 1'b1; mif.op = op; mif.srca = a; mif.srcb = b; mif.clear_exe = clr;
    @(posedge clk);
    #1 mif.start = 1'b0; mif.clear_exe = 1'b0;
    if (intrude) begin
      repeat (5) @(negedge clk);
      mif.start = 1'b1; mif.op = MDU_MTHI; mif.srca = $urandom;
      @(posedge clk);
      #1 mif.start = 1'b0;
    end
    wait_mon();
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: the accept edge follows each push; count busy cycles and compare at completion.
  initial begin
    exp_t e;
    int   cnt;
    bit   hold_ok;
    forever begin
      wait (sb_q.size() > 0);
      e = sb_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      cnt = 0;
      hold_ok = 1'b1;
      while (mif.busy === 1'b1 && cnt < 100) begin
        cnt++;
        if (mif.hi !== e.old_hi || mif.lo !== e.old_lo) hold_ok = 1'b0;
        @(negedge clk);
      end
      $display("txn %-9s lat=%0d hi=%h lo=%h (exp %h %h)", e.name, cnt, mif.hi, mif.lo, e.hi, e.lo);
      chk({e.name, "_busy_cycles"}, 64'(cnt), 64'(e.lat));
      if (e.lat > 0) chk({e.name, "_hold"}, 64'(hold_ok), 64'd1);
      chk({e.name, "_hi"}, 64'(mif.hi), 64'(e.hi));
      chk({e.name, "_lo"}, 64'(mif.lo), 64'(e.lo));
      mon_done++;
    end
  end

  initial begin
    mdu_op_t ops[6] = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};
    mif.start = 1'b0; mif.op = MDU_NONE; mif.srca = '0; mif.srcb = '0; mif.clear_exe = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(mif.busy), 64'd0);
    chk("reset_hi", 64'(mif.hi), 64'd0);
    chk("reset_lo", 64'(mif.lo), 64'd0);
    rst_n = 1'b1;

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    issue(MDU_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    issue(MDU_DIV,   -32'sd7,       32'd2, 1'b0, 1'b0);
    issue(MDU_DIVU,  32'd100,       32'd7, 1'b0, 1'b0);
    issue(MDU_DIVU,  32'd5,         32'd0, 1'b0, 1'b0);
    issue(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(MDU_DIV,   32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
    issue(MDU_MTHI,  32'h1234_5678, 32'd0, 1'b0, 1'b0);
    issue(MDU_MTLO,  32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
    issue(MDU_DIV,   32'd1000,      -32'sd9, 1'b0, 1'b1);
    issue(MDU_MTHI,  32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
    issue(MDU_MULT,  32'd77,        32'd3, 1'b1, 1'b0);
    issue(MDU_NONE,  32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);

    // Reset ten cycles into a multiply: everything clears at once.
    @(negedge clk);
    mif.start = 1'b1; mif.op = MDU_MULT; mif.srca = 32'd12345; mif.srcb = 32'd678;
    @(posedge clk);
    #1 mif.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("txn reset_mid busy=%0b hi=%h lo=%h", mif.busy, mif.hi, mif.lo);
    chk("rstmid_busy", 64'(mif.busy), 64'd0);
    chk("rstmid_hi", 64'(mif.hi), 64'd0);
    chk("rstmid_lo", 64'(mif.lo), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(MDU_MULT, 32'd3, 32'd4, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      issue(ops[$urandom_range(0, 5)], rnd_val(), rnd_val(), ($urandom_range(0, 9) == 0), 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
